multiport_fifo_queue: RTL

//  Circular FIFO with multiple enqueue and dequeue lanes per cycle, for superscalar front-end and dispatch buffering.

---
 rtl/multiport_fifo_queue_if.sv | 43 ++++
 rtl/multiport_fifo_queue.sv | 102 ++++++++++
 2 files changed

// File: rtl/multiport_fifo_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : multiport_fifo_queue_if
// Brief    : Producer/consumer bundle for the N-wide enqueue/dequeue FIFO.
// Revision : 1.0  initial release
// ============================================================================
interface multiport_fifo_queue_if #(
   parameter int DEPTH     = 16,
   parameter int WIDTH     = 32,
   parameter int ENQ_LANES = 2,
   parameter int DEQ_LANES = 2
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = $clog2(ENQ_LANES + 1);
   localparam int DW = $clog2(DEQ_LANES + 1);

   logic                       flush;
   logic [EW-1:0]              enq_cnt;
   logic [ENQ_LANES*WIDTH-1:0] enq_data;
   logic [DW-1:0]              deq_cnt;
   logic [DEQ_LANES*WIDTH-1:0] deq_data;
   logic [DEQ_LANES-1:0]       deq_valid;
   logic [CW-1:0]              count;
   logic [CW-1:0]              free_cnt;
   logic                       full;
   logic                       empty;
   logic                       almost_full;
   logic                       enq_rej;
   logic                       deq_rej;

   modport master (
      output flush, enq_cnt, enq_data, deq_cnt,
      input  deq_data, deq_valid, count, free_cnt, full, empty, almost_full,
             enq_rej, deq_rej
   );

   modport slave (
      input  flush, enq_cnt, enq_data, deq_cnt,
      output deq_data, deq_valid, count, free_cnt, full, empty, almost_full,
             enq_rej, deq_rej
   );
endinterface
`default_nettype wire

// File: rtl/multiport_fifo_queue.sv
`default_nettype none
// ============================================================================
// Module   : multiport_fifo_queue
// Brief    : Circular FIFO with all-or-nothing multi-lane enqueue/dequeue.
// Revision : 1.0  initial release
// ============================================================================
module multiport_fifo_queue #(
   parameter int DEPTH     = 16,
   parameter int WIDTH     = 32,
   parameter int ENQ_LANES = 2,
   parameter int DEQ_LANES = 2,
   parameter int AF_THRESH = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multiport_fifo_queue_if.slave  fifo_bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic             r_enq_rej;
   logic             r_deq_rej;

   logic [CW-1:0]    w_free;
   logic             w_enq_ok;
   logic             w_deq_ok;
   logic [CW-1:0]    w_count_next;

   // k never exceeds DEPTH, so a single conditional subtract covers any DEPTH.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      if (s >= DEPTH)
         s = s - DEPTH;
      return AW'(s);
   endfunction

   assign w_free   = CW'(DEPTH) - r_count;
   assign w_deq_ok = (32'(fifo_bus.deq_cnt) <= DEQ_LANES) &&
                     (32'(fifo_bus.deq_cnt) <= 32'(r_count));
   assign w_enq_ok = (32'(fifo_bus.enq_cnt) <= ENQ_LANES) &&
                     (32'(fifo_bus.enq_cnt) <= 32'(w_free));
   assign w_count_next = CW'(32'(r_count)
                           + (w_enq_ok ? 32'(fifo_bus.enq_cnt) : 32'd0)
                           - (w_deq_ok ? 32'(fifo_bus.deq_cnt) : 32'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_enq_rej <= 1'b0;
         r_deq_rej <= 1'b0;
      end else if (fifo_bus.flush) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_enq_rej <= 1'b0;
         r_deq_rej <= 1'b0;
      end else begin
         if (w_deq_ok)
            r_head <= wrap_add(r_head, 32'(fifo_bus.deq_cnt));
         if (w_enq_ok)
            r_tail <= wrap_add(r_tail, 32'(fifo_bus.enq_cnt));
         r_count   <= w_count_next;
         r_enq_rej <= !w_enq_ok;
         r_deq_rej <= !w_deq_ok;
      end
   end

   // Storage carries no reset; entries outside the occupied window are never observed.
   always_ff @(posedge clk) begin
      if (rst_n && !fifo_bus.flush && w_enq_ok) begin
         for (int i = 0; i < ENQ_LANES; i++) begin
            if (i < int'(fifo_bus.enq_cnt))
               r_mem[wrap_add(r_tail, i)] <= fifo_bus.enq_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      fifo_bus.deq_data  = '0;
      fifo_bus.deq_valid = '0;
      for (int i = 0; i < DEQ_LANES; i++) begin
         fifo_bus.deq_data[i*WIDTH +: WIDTH] = r_mem[wrap_add(r_head, i)];
         fifo_bus.deq_valid[i]               = (32'(r_count) > i);
      end
   end

   assign fifo_bus.count       = r_count;
   assign fifo_bus.free_cnt    = w_free;
   assign fifo_bus.full        = (r_count == CW'(DEPTH));
   assign fifo_bus.empty       = (r_count == '0);
   assign fifo_bus.almost_full = (32'(r_count) >= AF_THRESH);
   assign fifo_bus.enq_rej     = r_enq_rej;
   assign fifo_bus.deq_rej     = r_deq_rej;
endmodule
`default_nettype wire
